vga_tile_scheduler: RTL



---
 rtl/vga_pkg.sv | 39 +++
 rtl/tile_write_fifo.sv | 60 ++++++
 rtl/vga_tile_scheduler.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared types and timing constants for the VGA tile scheduler.
//   dir_t          - Pac-Man direction encoding (UP=0, RIGHT=1, DOWN=2, LEFT=3)
//   sched_state_t  - tile-RAM arbitration FSM states
//   timing         - 1280x480 active area inside a 1600x525 raster
//   in_write_window- decodes the blanking region in which tile writes may
//                    be issued to the shared RAM
package vga_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } sched_state_t;

    localparam int HACTIVE    = 1280;
    localparam int HTOTAL     = 1600;
    localparam int VACTIVE    = 480;
    localparam int VTOTAL     = 525;
    localparam int WIN_HSTART = 1288;
    localparam int WIN_HEND   = 1584;
    localparam int MAP_TILES  = 4800;
    localparam int RESET_X    = 340;
    localparam int RESET_Y    = 240;

    // The horizontal window stops 16 clocks before hcount wraps, so an
    // ISSUE entered from its last cycle still finishes before active video.
    // The vertical window excludes the last line for the same reason.
    function automatic logic in_write_window(input logic [10:0] h, input logic [9:0] v);
        return ((h >= 11'(WIN_HSTART)) && (h < 11'(WIN_HEND))) ||
               ((v >= 10'(VACTIVE)) && (v < 10'(VTOTAL - 1)));
    endfunction

endpackage

// File: rtl/tile_write_fifo.sv
// tile_write_fifo: synchronous FIFO buffering software tile writes until a
// blanking window lets them reach the tile RAM.
//   clk, reset - clock, synchronous active-high reset (pointers only)
//   push_i     - write wdata_i (ignored when full)
//   pop_i      - discard head entry (ignored when empty)
//   wdata_i    - entry to store
//   rdata_o    - current head entry (combinational read)
//   full_o     - no free slot
//   empty_o    - no stored entry
module tile_write_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit tells a full FIFO from an empty one.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; entries are only visible between pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/vga_tile_scheduler.sv
// vga_tile_scheduler: arbitrates the single-port tile RAM between display
// reads and buffered software writes, and commits Pac-Man sprite state once
// per frame at vertical-blank start.
//   clk, reset            - clock, synchronous active-high reset
//   chipselect, write,
//   address, writedata    - Avalon slave write port
//   waitrequest           - stalls a FIFO push while the buffer is full
//   hcount, vcount        - raster position from vga_counters
//   rd_addr               - display-path tile address
//   ram_addr, ram_we,
//   ram_wdata             - tile RAM port (combinational)
//   pacman_x/y/dir        - committed sprite state
//   frame_tick            - one-cycle pulse following each commit
module vga_tile_scheduler
    import vga_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TILE_ADDR_W = 13,
    parameter int TILE_DATA_W = 12,
    parameter int MAP_TILES   = vga_pkg::MAP_TILES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   chipselect,
    input  logic                   write,
    input  logic [2:0]             address,
    input  logic [15:0]            writedata,
    output logic                   waitrequest,
    input  logic [10:0]            hcount,
    input  logic [9:0]             vcount,
    input  logic [TILE_ADDR_W-1:0] rd_addr,
    output logic [TILE_ADDR_W-1:0] ram_addr,
    output logic                   ram_we,
    output logic [TILE_DATA_W-1:0] ram_wdata,
    output logic [9:0]             pacman_x,
    output logic [9:0]             pacman_y,
    output logic [1:0]             pacman_dir,
    output logic                   frame_tick
);
    localparam int ENTRY_W = TILE_ADDR_W + TILE_DATA_W;
    localparam logic [TILE_ADDR_W-1:0] ADDR_LIMIT = TILE_ADDR_W'(MAP_TILES);

    sched_state_t           state_q, state_d;
    logic [9:0]             shadow_x_q, shadow_x_d, shadow_y_q, shadow_y_d;
    dir_t                   shadow_dir_q, shadow_dir_d;
    logic [TILE_ADDR_W-1:0] staged_addr_q, staged_addr_d;
    logic [9:0]             pacman_x_q, pacman_y_q;
    dir_t                   pacman_dir_q;
    logic                   frame_tick_q;

    logic                   wr_fire, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]     fifo_head;
    logic                   win, commit;
    logic                   unused_wdata;

    assign unused_wdata = ^writedata[15:TILE_ADDR_W];

    assign waitrequest = chipselect && write && (address == 3'd4) && fifo_full;
    assign wr_fire     = chipselect && write && !waitrequest;
    // Out-of-range addresses are dropped here rather than stalled.
    assign fifo_push   = wr_fire && (address == 3'd4) && (staged_addr_q < ADDR_LIMIT);
    assign win         = in_write_window(hcount, vcount);
    assign commit      = (hcount == 11'd0) && (vcount == 10'(VACTIVE));

    tile_write_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i ({staged_addr_q, writedata[TILE_DATA_W-1:0]}),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        shadow_x_d    = shadow_x_q;
        shadow_y_d    = shadow_y_q;
        shadow_dir_d  = shadow_dir_q;
        staged_addr_d = staged_addr_q;
        if (wr_fire) begin
            case (address)
                3'd0:    shadow_x_d    = writedata[9:0];
                3'd1:    shadow_y_d    = writedata[9:0];
                3'd2:    shadow_dir_d  = dir_t'(writedata[1:0]);
                3'd3:    staged_addr_d = writedata[TILE_ADDR_W-1:0];
                default: ;
            endcase
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. ISSUE always lasts one cycle, so at most one RAM
    // write every two cycles.
    always_comb begin
        state_d = ST_IDLE;
        if (state_q == ST_IDLE && win && !fifo_empty) begin
            state_d = ST_ISSUE;
        end
    end

    // FSM: outputs. The head is presented even when idle; ram_we gates it.
    always_comb begin
        ram_addr  = rd_addr;
        ram_wdata = fifo_head[TILE_DATA_W-1:0];
        ram_we    = 1'b0;
        fifo_pop  = 1'b0;
        if (state_q == ST_ISSUE) begin
            ram_addr = fifo_head[ENTRY_W-1:TILE_DATA_W];
            ram_we   = 1'b1;
            fifo_pop = 1'b1;
        end
    end

    // Shadow registers and frame commit. A shadow write landing on the
    // commit cycle is seen by the next commit, since the committed copy
    // samples the pre-write shadow value.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_x_q    <= 10'(RESET_X);
            shadow_y_q    <= 10'(RESET_Y);
            shadow_dir_q  <= DIR_RIGHT;
            staged_addr_q <= '0;
            pacman_x_q    <= 10'(RESET_X);
            pacman_y_q    <= 10'(RESET_Y);
            pacman_dir_q  <= DIR_RIGHT;
            frame_tick_q  <= 1'b0;
        end else begin
            shadow_x_q    <= shadow_x_d;
            shadow_y_q    <= shadow_y_d;
            shadow_dir_q  <= shadow_dir_d;
            staged_addr_q <= staged_addr_d;
            frame_tick_q  <= commit;
            if (commit) begin
                pacman_x_q   <= shadow_x_q;
                pacman_y_q   <= shadow_y_q;
                pacman_dir_q <= shadow_dir_q;
            end
        end
    end

    assign pacman_x   = pacman_x_q;
    assign pacman_y   = pacman_y_q;
    assign pacman_dir = pacman_dir_q;
    assign frame_tick = frame_tick_q;

endmodule
